// File: rtl/read_operation_pkg.sv
// Shared constants for the register read/write blocks: register file shape,
// highest legal address and the read FSM state encodings.
package read_operation_pkg;

  localparam int NREG     = 7;
  localparam int DATA_W   = 32;
  localparam int MAX_ADDR = 6;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  // Advance a register pointer, wrapping from the last register back to 0.
  function automatic logic [2:0] next_ptr(input logic [2:0] ptr);
    if (ptr == 3'(MAX_ADDR)) begin
      return 3'd0;
    end
    return ptr + 3'd1;
  endfunction

endpackage

// File: rtl/read_operation_decoder.sv
// 8-bit address to 7-line one-hot decoder. Any address outside 0..6 yields an
// all-zero select, so an AND-OR mux driven by it returns zero data.
module _8_to_7_decoder (
  input  logic [7:0] addr,
  output logic [6:0] sel
);

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_sel
      assign sel[gi] = (addr == 8'(gi));
    end
  endgenerate

endmodule

// File: rtl/read_operation.sv
// Register read engine: single reads and wrapping bursts of up to 7 beats
// over a flattened register file, one beat per cycle, registered outputs.
// NREG must not exceed 7 (width of the shared decoder).
module read_operation #(
  parameter int DATA_W = read_operation_pkg::DATA_W,
  parameter int NREG   = read_operation_pkg::NREG
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   re,
  input  logic [7:0]             Addr,
  input  logic [2:0]             burst_len,
  input  logic [NREG*DATA_W-1:0] from_reg,
  output logic [DATA_W-1:0]      rdata,
  output logic                   rvalid,
  output logic                   rlast,
  output logic                   rerr,
  output logic                   busy
);

  import read_operation_pkg::*;

  logic [0:0]        state_reg;
  logic [2:0]        cnt_reg;
  logic [2:0]        ptr_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              rvalid_reg;
  logic              rlast_reg;
  logic              rerr_reg;

  logic [7:0]        sel_addr;
  logic [6:0]        sel;
  logic [DATA_W-1:0] term [NREG];
  logic [DATA_W-1:0] mux_data;
  logic              addr_valid;
  logic [2:0]        eff_len;

  // During a burst the beat comes from the internal pointer, otherwise from Addr.
  assign sel_addr   = (state_reg == BURST) ? {5'd0, ptr_reg} : Addr;
  assign addr_valid = (Addr[7:3] == 5'd0) && (Addr[2:0] <= 3'(MAX_ADDR));
  assign eff_len    = (burst_len == 3'd0) ? 3'd1 : burst_len;

  _8_to_7_decoder u_decoder (
    .addr (sel_addr),
    .sel  (sel)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_term
      assign term[gi] = from_reg[gi*DATA_W +: DATA_W] & {DATA_W{sel[gi]}};
    end
  endgenerate

  // AND-OR mux: OR together the masked register terms.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NREG; i++) begin
      mux_data = mux_data | term[i];
    end
  end

  // FSM, burst bookkeeping and registered beat outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 3'd0;
      ptr_reg    <= 3'd0;
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
      rlast_reg  <= 1'b0;
      rerr_reg   <= 1'b0;
    end else if (state_reg == BURST) begin
      rdata_reg  <= mux_data;
      rvalid_reg <= 1'b1;
      rerr_reg   <= 1'b0;
      ptr_reg    <= next_ptr(ptr_reg);
      cnt_reg    <= cnt_reg - 3'd1;
      if (cnt_reg == 3'd1) begin
        rlast_reg <= 1'b1;
        state_reg <= IDLE;
      end else begin
        rlast_reg <= 1'b0;
      end
    end else if (re) begin
      rvalid_reg <= 1'b1;
      if (!addr_valid) begin
        // Bad start address: one error beat with zero data, no burst.
        rdata_reg <= '0;
        rerr_reg  <= 1'b1;
        rlast_reg <= 1'b1;
      end else begin
        rdata_reg <= mux_data;
        rerr_reg  <= 1'b0;
        if (eff_len == 3'd1) begin
          rlast_reg <= 1'b1;
        end else begin
          rlast_reg <= 1'b0;
          state_reg <= BURST;
          cnt_reg   <= eff_len - 3'd1;
          ptr_reg   <= next_ptr(Addr[2:0]);
        end
      end
    end else begin
      // Idle with no request: strobes drop, rdata keeps its last value.
      rvalid_reg <= 1'b0;
      rlast_reg  <= 1'b0;
      rerr_reg   <= 1'b0;
    end
  end

  assign rdata  = rdata_reg;
  assign rvalid = rvalid_reg;
  assign rlast  = rlast_reg;
  assign rerr   = rerr_reg;
  assign busy   = (state_reg == BURST);

endmodule
